// File: rtl/memwb_stage_reg.sv
// Elastic MEM/WB pipeline register with a 2-entry skid buffer and write-back data select.
// Optional forwarding outputs are enabled by defining MEMWB_FWD_EN.
module memwb_stage_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic              WB_i,
  input  logic              WBSrc_i,
  input  logic [DATA_W-1:0] MemRdata_i,
  input  logic [DATA_W-1:0] ALUres_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              WB_o,
  output logic              WBSrc_o,
  output logic [DATA_W-1:0] MemRdata_o,
  output logic [DATA_W-1:0] ALUres_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic [DATA_W-1:0] wb_data_o
`ifdef MEMWB_FWD_EN
  ,
  output logic              fwd_valid_o,
  output logic [ADDR_W-1:0] fwd_rd_o,
  output logic [DATA_W-1:0] fwd_data_o
`endif
);

  // Occupancy: OCC1 means head only, OCC2 means head plus skid.
  localparam logic [1:0] OCC0 = 2'd0;
  localparam logic [1:0] OCC1 = 2'd1;
  localparam logic [1:0] OCC2 = 2'd2;

  logic [1:0]        occ_q, occ_d;
  logic              head_wb_q, head_wb_d;
  logic              head_src_q, head_src_d;
  logic [DATA_W-1:0] head_mem_q, head_mem_d;
  logic [DATA_W-1:0] head_alu_q, head_alu_d;
  logic [ADDR_W-1:0] head_rd_q, head_rd_d;
  logic              skid_wb_q, skid_wb_d;
  logic              skid_src_q, skid_src_d;
  logic [DATA_W-1:0] skid_mem_q, skid_mem_d;
  logic [DATA_W-1:0] skid_alu_q, skid_alu_d;
  logic [ADDR_W-1:0] skid_rd_q, skid_rd_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic              wb_out_q, wb_out_d;
  logic              accept_c, pop_c;

`ifdef MEMWB_FWD_EN
  logic              fwd_valid_q, fwd_valid_d;
  logic [ADDR_W-1:0] fwd_rd_q, fwd_rd_d;
  logic [DATA_W-1:0] fwd_data_q, fwd_data_d;
`endif

  assign accept_c = in_valid_i & in_ready_q;
  assign pop_c    = out_valid_q & out_ready_i;

  // State and payload registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      occ_q       <= OCC0;
      head_wb_q   <= 1'b0;
      head_src_q  <= 1'b0;
      head_mem_q  <= '0;
      head_alu_q  <= '0;
      head_rd_q   <= '0;
      skid_wb_q   <= 1'b0;
      skid_src_q  <= 1'b0;
      skid_mem_q  <= '0;
      skid_alu_q  <= '0;
      skid_rd_q   <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      wb_out_q    <= 1'b0;
`ifdef MEMWB_FWD_EN
      fwd_valid_q <= 1'b0;
      fwd_rd_q    <= '0;
      fwd_data_q  <= '0;
`endif
    end else begin
      occ_q       <= occ_d;
      head_wb_q   <= head_wb_d;
      head_src_q  <= head_src_d;
      head_mem_q  <= head_mem_d;
      head_alu_q  <= head_alu_d;
      head_rd_q   <= head_rd_d;
      skid_wb_q   <= skid_wb_d;
      skid_src_q  <= skid_src_d;
      skid_mem_q  <= skid_mem_d;
      skid_alu_q  <= skid_alu_d;
      skid_rd_q   <= skid_rd_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      wb_out_q    <= wb_out_d;
`ifdef MEMWB_FWD_EN
      fwd_valid_q <= fwd_valid_d;
      fwd_rd_q    <= fwd_rd_d;
      fwd_data_q  <= fwd_data_d;
`endif
    end
  end

  // Next-state: occupancy transitions, payload moves and registered status outputs.
  always_comb begin
    occ_d      = occ_q;
    head_wb_d  = head_wb_q;
    head_src_d = head_src_q;
    head_mem_d = head_mem_q;
    head_alu_d = head_alu_q;
    head_rd_d  = head_rd_q;
    skid_wb_d  = skid_wb_q;
    skid_src_d = skid_src_q;
    skid_mem_d = skid_mem_q;
    skid_alu_d = skid_alu_q;
    skid_rd_d  = skid_rd_q;
`ifdef MEMWB_FWD_EN
    fwd_valid_d = 1'b0;
    fwd_rd_d    = fwd_rd_q;
    fwd_data_d  = fwd_data_q;
`endif

    if (flush_i) begin
      // Payloads are kept; only validity is dropped, including any same-cycle accept.
      occ_d = OCC0;
    end else begin
      case (occ_q)
        OCC0: begin
          if (accept_c) begin
            head_wb_d  = WB_i;
            head_src_d = WBSrc_i;
            head_mem_d = MemRdata_i;
            head_alu_d = ALUres_i;
            head_rd_d  = rd_addr_i;
            occ_d      = OCC1;
          end
        end
        OCC1: begin
          if (accept_c && pop_c) begin
            head_wb_d  = WB_i;
            head_src_d = WBSrc_i;
            head_mem_d = MemRdata_i;
            head_alu_d = ALUres_i;
            head_rd_d  = rd_addr_i;
          end else if (accept_c) begin
            skid_wb_d  = WB_i;
            skid_src_d = WBSrc_i;
            skid_mem_d = MemRdata_i;
            skid_alu_d = ALUres_i;
            skid_rd_d  = rd_addr_i;
            occ_d      = OCC2;
          end else if (pop_c) begin
            occ_d = OCC0;
          end
        end
        OCC2: begin
          if (pop_c) begin
            head_wb_d  = skid_wb_q;
            head_src_d = skid_src_q;
            head_mem_d = skid_mem_q;
            head_alu_d = skid_alu_q;
            head_rd_d  = skid_rd_q;
            occ_d      = OCC1;
          end
        end
        default: occ_d = OCC0;
      endcase
    end

    in_ready_d  = (occ_d != OCC2);
    out_valid_d = (occ_d != OCC0);
    wb_out_d    = head_wb_d & out_valid_d & (head_rd_d != '0);

`ifdef MEMWB_FWD_EN
    // Youngest qualifying entry wins: skid first, then head.
    if ((occ_d == OCC2) && skid_wb_d && (skid_rd_d != '0)) begin
      fwd_valid_d = 1'b1;
      fwd_rd_d    = skid_rd_d;
      fwd_data_d  = skid_src_d ? skid_mem_d : skid_alu_d;
    end else if ((occ_d != OCC0) && head_wb_d && (head_rd_d != '0)) begin
      fwd_valid_d = 1'b1;
      fwd_rd_d    = head_rd_d;
      fwd_data_d  = head_src_d ? head_mem_d : head_alu_d;
    end
`endif
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign WB_o        = wb_out_q;
  assign WBSrc_o     = head_src_q;
  assign MemRdata_o  = head_mem_q;
  assign ALUres_o    = head_alu_q;
  assign rd_addr_o   = head_rd_q;
  assign wb_data_o   = head_src_q ? head_mem_q : head_alu_q;

`ifdef MEMWB_FWD_EN
  assign fwd_valid_o = fwd_valid_q;
  assign fwd_rd_o    = fwd_rd_q;
  assign fwd_data_o  = fwd_data_q;
`endif

endmodule

// File: tb/tb_memwb_stage_reg.sv
// Bench for memwb_stage_reg: directed vector table, async reset check and
// randomized traffic against a queue-based reference model.
module tb_memwb_stage_reg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic              wb_in;
  logic              src_in;
  logic [DATA_W-1:0] mem_in;
  logic [DATA_W-1:0] alu_in;
  logic [ADDR_W-1:0] rd_in;
  logic              out_valid;
  logic              out_ready;
  logic              wb_out;
  logic              src_out;
  logic [DATA_W-1:0] mem_out;
  logic [DATA_W-1:0] alu_out;
  logic [ADDR_W-1:0] rd_out;
  logic [DATA_W-1:0] wb_data;
`ifdef MEMWB_FWD_EN
  logic              fwd_valid;
  logic [ADDR_W-1:0] fwd_rd;
  logic [DATA_W-1:0] fwd_data;
`endif

  always #5 clk = ~clk;

  memwb_stage_reg #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .WB_i        (wb_in),
    .WBSrc_i     (src_in),
    .MemRdata_i  (mem_in),
    .ALUres_i    (alu_in),
    .rd_addr_i   (rd_in),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .WB_o        (wb_out),
    .WBSrc_o     (src_out),
    .MemRdata_o  (mem_out),
    .ALUres_o    (alu_out),
    .rd_addr_o   (rd_out),
    .wb_data_o   (wb_data)
`ifdef MEMWB_FWD_EN
    ,
    .fwd_valid_o (fwd_valid),
    .fwd_rd_o    (fwd_rd),
    .fwd_data_o  (fwd_data)
`endif
  );

  typedef struct {
    logic        fl, iv, ord, wb, src;
    logic [31:0] mem, alu;
    logic [4:0]  rd;
    logic        e_ov, e_ir, e_wb;
    logic [31:0] e_data;
  } vec_t;

  typedef struct packed {
    logic        wb, src;
    logic [31:0] mem, alu;
    logic [4:0]  rd;
  } ent_t;

  int n_checks = 0;
  int n_fail   = 0;

  ent_t m_q[$];
  ent_t m_shown;
  logic m_ready;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic fl, input logic iv, input logic ord, input logic wb,
                       input logic src, input logic [31:0] mem, input logic [31:0] alu,
                       input logic [4:0] rd);
    flush = fl; in_valid = iv; out_ready = ord;
    wb_in = wb; src_in = src; mem_in = mem; alu_in = alu; rd_in = rd;
  endtask

  function automatic vec_t mk(input logic fl, input logic iv, input logic ord, input logic wb,
                              input logic src, input logic [31:0] mem, input logic [31:0] alu,
                              input logic [4:0] rd, input logic e_ov, input logic e_ir,
                              input logic e_wb, input logic [31:0] e_data);
    vec_t v;
    v.fl = fl; v.iv = iv; v.ord = ord; v.wb = wb; v.src = src;
    v.mem = mem; v.alu = alu; v.rd = rd;
    v.e_ov = e_ov; v.e_ir = e_ir; v.e_wb = e_wb; v.e_data = e_data;
    return v;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_shown = '0;
    m_ready = 1'b1;
  endtask

  // Async reset pulse placed mid-cycle; outputs must clear before the next edge.
  task automatic mid_reset(input string tag);
    #3 rst = 1'b1;
    #1;
    chk({tag, "_ov"},   32'(out_valid), 32'd0);
    chk({tag, "_ir"},   32'(in_ready),  32'd1);
    chk({tag, "_wb"},   32'(wb_out),    32'd0);
    chk({tag, "_data"}, wb_data,        32'd0);
    drive(0, 0, 0, 0, 0, 32'd0, 32'd0, 5'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  vec_t vecs[19];

  initial begin
    ent_t it;
    logic acc, pop;

    vecs[0]  = mk(0,1,1,1,0,32'h0,32'h11,5'd5,        1,1,1,32'h11);
    vecs[1]  = mk(0,1,1,1,0,32'h0,32'h22,5'd5,        1,1,1,32'h22);
    vecs[2]  = mk(0,1,1,1,0,32'h0,32'h33,5'd5,        1,1,1,32'h33);
    vecs[3]  = mk(0,0,1,1,0,32'h0,32'h0,5'd5,         0,1,0,32'h33);
    vecs[4]  = mk(0,1,0,1,0,32'h0,32'hA1,5'd5,        1,1,1,32'hA1);
    vecs[5]  = mk(0,1,0,1,0,32'h0,32'hB2,5'd5,        1,0,1,32'hA1);
    vecs[6]  = mk(0,1,0,1,0,32'h0,32'hC3,5'd5,        1,0,1,32'hA1);
    vecs[7]  = mk(0,1,1,1,0,32'h0,32'hC3,5'd5,        1,1,1,32'hB2);
    vecs[8]  = mk(0,1,1,1,0,32'h0,32'hC3,5'd5,        1,1,1,32'hC3);
    vecs[9]  = mk(0,0,1,1,0,32'h0,32'h0,5'd5,         0,1,0,32'hC3);
    vecs[10] = mk(0,1,0,1,1,32'hDEADBEEF,32'h5,5'd0,  1,1,0,32'hDEADBEEF);
    vecs[11] = mk(0,0,1,1,0,32'h0,32'h0,5'd5,         0,1,0,32'hDEADBEEF);
    vecs[12] = mk(0,1,0,1,0,32'h0,32'h51,5'd5,        1,1,1,32'h51);
    vecs[13] = mk(0,1,0,1,0,32'h0,32'h52,5'd5,        1,0,1,32'h51);
    vecs[14] = mk(1,1,0,1,0,32'h0,32'h53,5'd5,        0,1,0,32'h51);
    vecs[15] = mk(0,0,1,1,0,32'h0,32'h0,5'd5,         0,1,0,32'h51);
    vecs[16] = mk(0,1,0,1,0,32'h0,32'h61,5'd5,        1,1,1,32'h61);
    vecs[17] = mk(1,1,0,1,0,32'h0,32'h62,5'd5,        0,1,0,32'h61);
    vecs[18] = mk(0,0,1,1,0,32'h0,32'h0,5'd5,         0,1,0,32'h61);

    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 32'd0, 32'd0, 5'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ov",   32'(out_valid), 32'd0);
    chk("rst_ir",   32'(in_ready),  32'd1);
    chk("rst_wb",   32'(wb_out),    32'd0);
    chk("rst_data", wb_data,        32'd0);
    chk("rst_rd",   32'(rd_out),    32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed table: streaming, backpressure, source select / x0, flush.
    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].fl, vecs[i].iv, vecs[i].ord, vecs[i].wb, vecs[i].src,
            vecs[i].mem, vecs[i].alu, vecs[i].rd);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_ov", i),   32'(out_valid), 32'(vecs[i].e_ov));
      chk($sformatf("v%0d_ir", i),   32'(in_ready),  32'(vecs[i].e_ir));
      chk($sformatf("v%0d_wb", i),   32'(wb_out),    32'(vecs[i].e_wb));
      chk($sformatf("v%0d_data", i), wb_data,        vecs[i].e_data);
    end

    // Reset while two entries are held.
    drive(0, 1, 0, 1, 0, 32'h0, 32'h71, 5'd7);
    @(posedge clk); #1;
    drive(0, 1, 0, 1, 0, 32'h0, 32'h72, 5'd7);
    @(posedge clk); #1;
    chk("pre_rst_ir", 32'(in_ready), 32'd0);
    mid_reset("midrst");

    // Randomized traffic against the FIFO reference model.
    for (int c = 0; c < 3000; c++) begin
      it.wb  = 1'($urandom_range(0, 1));
      it.src = 1'($urandom_range(0, 1));
      it.mem = $urandom;
      it.alu = $urandom;
      it.rd  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      drive(($urandom_range(0, 19) == 0), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)), it.wb, it.src, it.mem, it.alu, it.rd);
      acc = in_valid & m_ready;
      pop = (m_q.size() > 0) & out_ready;
      @(posedge clk);
      if (flush) m_q.delete();
      else begin
        if (pop) void'(m_q.pop_front());
        if (acc) m_q.push_back(it);
      end
      m_ready = (m_q.size() < 2);
      if (m_q.size() > 0) m_shown = m_q[0];
      #1;
      chk("rnd_ov",   32'(out_valid), 32'(m_q.size() > 0));
      chk("rnd_ir",   32'(in_ready),  32'(m_ready));
      chk("rnd_wb",   32'(wb_out),    32'((m_q.size() > 0) && m_shown.wb && (m_shown.rd != 0)));
      chk("rnd_data", wb_data,        m_shown.src ? m_shown.mem : m_shown.alu);
      chk("rnd_rd",   32'(rd_out),    32'(m_shown.rd));
      chk("rnd_src",  32'(src_out),   32'(m_shown.src));
      chk("rnd_mem",  mem_out,        m_shown.mem);
      chk("rnd_alu",  alu_out,        m_shown.alu);
`ifdef MEMWB_FWD_EN
      begin
        logic        fv;
        logic [4:0]  frd;
        logic [31:0] fd;
        fv = 1'b0; frd = 5'd0; fd = 32'd0;
        for (int k = m_q.size() - 1; k >= 0; k--) begin
          if (!fv && m_q[k].wb && (m_q[k].rd != 0)) begin
            fv = 1'b1; frd = m_q[k].rd; fd = m_q[k].src ? m_q[k].mem : m_q[k].alu;
          end
        end
        chk("rnd_fwd_v", 32'(fwd_valid), 32'(fv));
        if (fv) begin
          chk("rnd_fwd_rd",   32'(fwd_rd), 32'(frd));
          chk("rnd_fwd_data", fwd_data,    fd);
        end
      end
`endif
    end

`ifdef MEMWB_FWD_EN
    // Forwarding prefers the skid entry and keeps it after the head pops.
    mid_reset("fwdrst");
    drive(0, 1, 0, 1, 0, 32'h0, 32'hAA, 5'd3);
    @(posedge clk); #1;
    drive(0, 1, 0, 1, 0, 32'h0, 32'hBB, 5'd3);
    @(posedge clk); #1;
    chk("fwd_v",    32'(fwd_valid), 32'd1);
    chk("fwd_rd",   32'(fwd_rd),    32'd3);
    chk("fwd_data", fwd_data,       32'hBB);
    drive(0, 0, 1, 0, 0, 32'h0, 32'h0, 5'd0);
    @(posedge clk); #1;
    chk("fwd_pop_data", fwd_data,       32'hBB);
    chk("fwd_pop_v",    32'(fwd_valid), 32'd1);
    drive(1, 0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
    @(posedge clk); #1;
    chk("fwd_flush_v",  32'(fwd_valid), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
